// File: rtl/pulse_train_pkg.sv
// Shared types and default widths for the pulse train generator.
package pulse_train_pkg;

  localparam int unsigned DEF_LEN_W = 8;
  localparam int unsigned DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// Loadable down-counter; expire_c flags the last cycle of a loaded phase.
module phase_timer
  import pulse_train_pkg::*;
#(
  parameter int unsigned W = DEF_LEN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire_c
);

  logic [W-1:0] cnt_q;

  // Holds the remaining cycles of the current phase, including this one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expire_c = (cnt_q == W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Emits a programmed train of rectangular pulses on dout after a start request.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [CNT_W-1:0] num_pulses,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] high_len_q, low_len_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] cnt_d;
  logic             done_d;
  logic             latch_c;
  logic             load_c;
  logic [LEN_W-1:0] load_val_c;
  logic [LEN_W-1:0] low_eff_c;
  logic             expire_c;

  // A zero gap would merge adjacent pulses, so it is stretched to one cycle.
  assign low_eff_c = (low_len_q == '0) ? LEN_W'(1) : low_len_q;

  phase_timer #(
    .W (LEN_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .load_val (load_val_c),
    .expire_c (expire_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dout       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pulse_cnt  <= '0;
      high_len_q <= '0;
      low_len_q  <= '0;
      num_q      <= '0;
    end else begin
      state_q   <= state_d;
      dout      <= (state_d == HIGH);
      busy      <= (state_d != IDLE);
      done      <= done_d;
      pulse_cnt <= cnt_d;
      if (latch_c) begin
        high_len_q <= high_len;
        low_len_q  <= low_len;
        num_q      <= num_pulses;
      end
    end
  end

  // Next state; the timer is loaded on every phase entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = pulse_cnt;
    done_d     = 1'b0;
    latch_c    = 1'b0;
    load_c     = 1'b0;
    load_val_c = '0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            latch_c = 1'b1;
            cnt_d   = '0;
            if (high_len == '0 || num_pulses == '0) begin
              done_d = 1'b1;
            end else begin
              state_d    = HIGH;
              load_c     = 1'b1;
              load_val_c = high_len;
              cnt_d      = CNT_W'(1);
            end
          end
        end
        HIGH: begin
          if (expire_c) begin
            if (pulse_cnt == num_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d    = LOW;
              load_c     = 1'b1;
              load_val_c = low_eff_c;
            end
          end
        end
        LOW: begin
          if (expire_c) begin
            state_d    = HIGH;
            load_c     = 1'b1;
            load_val_c = high_len_q;
            cnt_d      = pulse_cnt + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
Transmit-side counterpart to edge_detector. On a start request it drives a single-bit level line with a programmed train of rectangular pulses. Each pulse is high for a programmed number of cycles and is followed by a programmed low gap. The output feeds a downstream edge_detector's din, which must see exactly one rising edge per pulse. The block is used as a stimulus and event source in the sequential-logic library.

Parameters:
LEN_W, 8, width of high_len / low_len phase-length inputs (cycles)
CNT_W, 4, width of num_pulses and pulse_cnt

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a train; sampled only when busy=0
abort  input  1  terminate the current train immediately; priority over start
high_len  input  LEN_W  high-phase length in cycles; latched on accepted start
low_len  input  LEN_W  low-gap length in cycles; latched on accepted start
num_pulses  input  CNT_W  pulses per train; latched on accepted start
dout  output  1  generated level waveform, registered
busy  output  1  train in progress, registered
done  output  1  one-cycle pulse on normal completion, registered
pulse_cnt  output  CNT_W  rising edges emitted in the current/last train, registered

Behaviour:
- Reset (rst=1 at a clk edge): dout=0, busy=0, done=0, pulse_cnt=0, FSM=IDLE. Reset mid-train abandons it; no done.
- FSM states: IDLE, HIGH, LOW.
- IDLE + start=1 + abort=0 (cycle 0):
  - latch high_len, low_len, num_pulses; clear pulse_cnt.
  - If latched high_len==0 or num_pulses==0: stay IDLE, done=1 in cycle 1, dout stays 0, busy stays 0.
  - Otherwise enter HIGH: dout=1 and busy=1 from cycle 1; pulse_cnt increments in cycle 1.
- HIGH: dout=1 for exactly high_len cycles.
  - After the final high cycle, if pulses remain: go to LOW.
  - After the final high cycle of the last pulse: go to IDLE. The next cycle has dout=0, busy=0, done=1 for one cycle. No trailing low gap.
- LOW: dout=0 for max(low_len,1) cycles, then HIGH; pulse_cnt increments on the first high cycle. low_len=0 is forced to 1 so that edges remain detectable.
- Timing for a train: cycle period = high_len + max(low_len,1). Total busy cycles = N*high_len + (N-1)*max(low_len,1).
- start while busy=1: ignored. The latched configuration is unchanged.
- abort=1 in any state: next cycle dout=0, busy=0, done=0, FSM=IDLE; pulse_cnt holds its value. Abort in IDLE has no effect except blocking a simultaneous start.
- start on the same cycle that done is asserted: accepted (FSM is IDLE). The new train's first high cycle follows, so the low gap between trains is exactly 1 cycle.
- Config inputs may change freely while busy; only the latched copies are used.
- pulse_cnt saturates naturally, since it never exceeds num_pulses ≤ 2^CNT_W-1.

Decomposition:
- Package pulse_train_pkg: FSM state enum (IDLE, HIGH, LOW) and default width constants LEN_W=8, CNT_W=4.
- One sub-module, phase_timer: loadable down-counter (load, load_val, expire flag), reused for both high and low phases.
- The top level holds the FSM, pulse counter and output registers.

Test Plan:
- high_len=3, low_len=2, num_pulses=2, start at cycle 0:
  - dout=1 in cycles 1-3, 0 in 4-5, 1 in 6-8.
  - done=1 in cycle 9; busy=1 in cycles 1-8; pulse_cnt=2.
- high_len=0 or num_pulses=0, start: dout never rises, busy stays 0, done=1 exactly in cycle 1, pulse_cnt=0.
- high_len=1, low_len=0, num_pulses=3: dout = 1,0,1,0,1 over cycles 1-5, done in cycle 6. A loopback edge_detector asserts rising_edge 3 times.
- high_len=4, low_len=4, num_pulses=5; abort during the 2nd pulse's high phase: dout=0 and busy=0 the next cycle, no done, pulse_cnt=2. A start pulsed mid-train with different config is ignored (waveform unchanged).
- Back-to-back: start asserted again on the done cycle: the second train begins the next cycle and the gap between trains is 1 low cycle. Then rst=1 during the second train's LOW phase: all outputs 0 the next cycle and no done ever.
